// File: rtl/mfp_uart_tx_if.sv
// FIFO-side handshake between the MFP output FIFO and the UART transmitter.
// The master is the FIFO (offers a byte), the slave is the transmitter (pops it).
interface mfp_uart_tx_if;
  logic       data_available;
  logic [7:0] data;
  logic       strobe;

  modport master (output data_available, output data, input strobe);
  modport slave  (input data_available, input data, output strobe);
endinterface

// File: rtl/mfp_uart_tx.sv
// Asynchronous serial transmitter draining the MFP output FIFO onto a TXD pin.
// Frame format and bit rate are decoded from the MFP 64-bit serial status word.
module mfp_uart_tx #(
  parameter int CLK_HZ = 32000000
) (
  input  logic         clk,
  input  logic         reset,
  mfp_uart_tx_if.slave fifo,
  input  logic [63:0]  status,
  input  logic         cts_n,
  output logic         txd,
  output logic         busy
);

  localparam logic [32:0] CLK_MOD = 33'(CLK_HZ);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_acc;
  logic [31:0] r_rate;
  logic [2:0]  r_half;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_par;
  logic        r_par_en;
  logic [3:0]  r_nbits;
  logic [2:0]  r_stop_ticks;

  logic [31:0] w_rate;
  logic [3:0]  w_nbits;
  logic [7:0]  w_mask;
  logic        w_db_ok;
  logic        w_par_en;
  logic        w_par_odd;
  logic        w_par_ok;
  logic [2:0]  w_stop_ticks;
  logic        w_stop_ok;
  logic        w_rate_ok;
  logic        w_cfg_ok;
  logic        w_par_bit;
  logic [32:0] w_sum;
  logic        w_tick;
  logic [31:0] w_acc_nxt;
  logic [2:0]  w_need;
  logic        w_bit_done;
  logic        w_last_data;
  logic        w_strobe;
  logic        w_txd;
  logic        w_unused;

  // Bit rate is stored byte-reversed in the top half of the status word.
  assign w_rate   = {status[39:32], status[47:40], status[55:48], status[63:56]};
  assign w_unused = ^status[7:0];

  always_comb begin
    w_nbits      = 4'd8;
    w_mask       = 8'hFF;
    w_db_ok      = 1'b1;
    w_par_en     = 1'b0;
    w_par_odd    = 1'b0;
    w_par_ok     = 1'b1;
    w_stop_ticks = 3'd2;
    w_stop_ok    = 1'b1;
    case (status[31:24])
      8'h08:   begin w_nbits = 4'd8; w_mask = 8'hFF; end
      8'h07:   begin w_nbits = 4'd7; w_mask = 8'h7F; end
      8'h06:   begin w_nbits = 4'd6; w_mask = 8'h3F; end
      8'h05:   begin w_nbits = 4'd5; w_mask = 8'h1F; end
      default: w_db_ok = 1'b0;
    endcase
    case (status[23:16])
      8'h00:   w_par_en = 1'b0;
      8'h01:   begin w_par_en = 1'b1; w_par_odd = 1'b1; end
      8'h02:   w_par_en = 1'b1;
      default: w_par_ok = 1'b0;
    endcase
    // Stop length counted in half-bit ticks; the synchronous-mode code is rejected.
    case (status[15:8])
      8'h00:   w_stop_ticks = 3'd2;
      8'h01:   w_stop_ticks = 3'd3;
      8'h11:   w_stop_ticks = 3'd4;
      default: w_stop_ok = 1'b0;
    endcase
  end

  assign w_rate_ok = ~w_rate[31] && (w_rate != 32'd0) && ({w_rate, 1'b0} < CLK_MOD);
  assign w_cfg_ok  = w_rate_ok && w_db_ok && w_par_ok && w_stop_ok;
  assign w_par_bit = (^(fifo.data & w_mask)) ^ w_par_odd;

  // Fractional half-bit generator: one tick per CLK_HZ/(2*bitrate) cycles on average.
  assign w_sum       = {1'b0, r_acc} + {r_rate, 1'b0};
  assign w_tick      = (w_sum >= CLK_MOD);
  assign w_acc_nxt   = w_tick ? 32'(w_sum - CLK_MOD) : w_sum[31:0];
  assign w_need      = (r_state == STOP) ? r_stop_ticks : 3'd2;
  assign w_bit_done  = w_tick && (3'(r_half + 3'd1) == w_need);
  assign w_last_data = ({1'b0, r_bit} == (r_nbits - 4'd1));

  always_comb begin
    w_state_nxt = r_state;
    w_strobe    = 1'b0;
    w_txd       = 1'b1;
    case (r_state)
      IDLE: begin
        if (!reset && fifo.data_available && !cts_n && w_cfg_ok) begin
          w_strobe    = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        w_txd = 1'b0;
        if (w_bit_done) w_state_nxt = DATA;
      end
      DATA: begin
        w_txd = r_shift[0];
        if (w_bit_done && w_last_data) w_state_nxt = r_par_en ? PARITY : STOP;
      end
      PARITY: begin
        w_txd = r_par;
        if (w_bit_done) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_bit_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_acc        <= 32'd0;
      r_rate       <= 32'd0;
      r_half       <= 3'd0;
      r_bit        <= 3'd0;
      r_shift      <= 8'd0;
      r_par        <= 1'b0;
      r_par_en     <= 1'b0;
      r_nbits      <= 4'd8;
      r_stop_ticks <= 3'd2;
    end else begin
      r_state <= w_state_nxt;
      if (w_strobe) begin
        r_shift      <= fifo.data;
        r_par        <= w_par_bit;
        r_par_en     <= w_par_en;
        r_nbits      <= w_nbits;
        r_stop_ticks <= w_stop_ticks;
        r_rate       <= w_rate;
        r_acc        <= 32'd0;
        r_half       <= 3'd0;
        r_bit        <= 3'd0;
      end else if (r_state != IDLE) begin
        r_acc <= w_acc_nxt;
        if (w_bit_done) begin
          r_half <= 3'd0;
          if (r_state == DATA) begin
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 3'd1;
          end
        end else if (w_tick) begin
          r_half <= r_half + 3'd1;
        end
      end
    end
  end

  assign fifo.strobe = w_strobe;
  assign txd         = w_txd;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_mfp_uart_tx.sv
// Directed bench for mfp_uart_tx: table of frame formats plus multi-cycle corner sequences.
module tb_mfp_uart_tx;
  localparam int CLK_HZ = 192000;

  typedef struct {
    logic [31:0] rate;
    logic [7:0]  db;
    logic [7:0]  par;
    logic [7:0]  stp;
    logic [7:0]  byte_v;
    int          nlev;
    logic [11:0] lev;
    int          bitclk;
    int          stopclk;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cts_n = 1'b1;
  logic [63:0] status = 64'd0;
  logic        txd;
  logic        busy;

  mfp_uart_tx_if ifc();

  mfp_uart_tx #(.CLK_HZ(CLK_HZ)) dut (
    .clk    (clk),
    .reset  (reset),
    .fifo   (ifc),
    .status (status),
    .cts_n  (cts_n),
    .txd    (txd),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         n_strobe = 0;
  int         viol = 0;
  bit         prev_strobe = 1'b0;
  bit         fifo_s;
  int         strobe_times[$];
  logic [7:0] q[$];
  vec_t       vecs[5];

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: log every pop, flag pops while busy or on consecutive cycles.
  always @(negedge clk) begin
    if (ifc.strobe === 1'b1) begin
      n_strobe++;
      strobe_times.push_back(cyc);
      if (busy !== 1'b0 || prev_strobe) viol++;
    end
    prev_strobe = (ifc.strobe === 1'b1);
  end

  // FIFO model: pops its head after each sampled strobe.
  always begin
    @(negedge clk);
    fifo_s = (ifc.strobe === 1'b1);
    @(posedge clk);
    #1;
    if (fifo_s && q.size() > 0) void'(q.pop_front());
    ifc.data_available = (q.size() > 0);
    ifc.data           = (q.size() > 0) ? q[0] : 8'h00;
  end

  function automatic logic [63:0] mkstat(input logic [31:0] rate, input logic [7:0] db,
                                         input logic [7:0] par, input logic [7:0] stp);
    return {rate[7:0], rate[15:8], rate[23:16], rate[31:24], db, par, stp, 8'h00};
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic wait_strobe(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ifc.strobe === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, "_strobe_seen"}, ok, 1);
  endtask

  task automatic check_frame(input vec_t v, input string nm);
    int dur;
    int bad;
    for (int k = 0; k < v.nlev; k++) begin
      dur = (k == v.nlev - 1) ? v.stopclk : v.bitclk;
      bad = 0;
      for (int c = 0; c < dur; c++) begin
        @(negedge clk);
        if (txd !== v.lev[k] || busy !== 1'b1) bad++;
      end
      chk($sformatf("%s_bit%0d_bad_cycles", nm, k), bad, 0);
    end
    @(negedge clk);
    chk({nm, "_end_busy_txd"}, {busy, txd}, 2'b01);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int n0;
    bit ok;
    @(posedge clk);
    #1;
    status = mkstat(v.rate, v.db, v.par, v.stp);
    cts_n  = 1'b0;
    q.push_back(v.byte_v);
    n0 = n_strobe;
    wait_strobe(nm, ok);
    if (ok) check_frame(v, nm);
    chk({nm, "_strobe_count"}, n_strobe - n0, 1);
  endtask

  initial begin
    int   n0;
    int   bad;
    bit   ok;
    vec_t va5;

    vecs[0] = '{32'd9600, 8'h08, 8'h00, 8'h00, 8'h55, 10, 12'h2AA, 20, 20};
    vecs[1] = '{32'd9600, 8'h07, 8'h02, 8'h11, 8'hC3, 10, 12'h386, 20, 40};
    vecs[2] = '{32'd9600, 8'h05, 8'h01, 8'h01, 8'h1F,  8, 12'h0BE, 20, 30};
    vecs[3] = '{32'd4800, 8'h08, 8'h01, 8'h11, 8'hA0, 11, 12'h740, 40, 80};
    vecs[4] = '{32'd9600, 8'h06, 8'h02, 8'h00, 8'hFF,  9, 12'h17E, 20, 20};
    va5     = '{32'd9600, 8'h08, 8'h00, 8'h00, 8'hA5, 10, 12'h34A, 20, 20};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_txd", txd, 1);
    chk("reset_busy", busy, 0);
    chk("reset_strobe", ifc.strobe, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Table of frame formats
    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Three queued bytes, back to back
    @(posedge clk);
    #1;
    status = mkstat(32'd9600, 8'h08, 8'h00, 8'h00);
    strobe_times.delete();
    q.push_back(8'h55);
    q.push_back(8'h55);
    q.push_back(8'h55);
    wait_strobe("b2b", ok);
    if (ok) begin
      check_frame(vecs[0], "b2b0");
      check_frame(vecs[0], "b2b1");
      check_frame(vecs[0], "b2b2");
    end
    chk("b2b_strobe_count", strobe_times.size(), 3);
    if (strobe_times.size() == 3) begin
      chk("b2b_gap1", strobe_times[1] - strobe_times[0], 201);
      chk("b2b_gap2", strobe_times[2] - strobe_times[1], 201);
    end

    // Invalid configurations: bit 31 of the rate set, then sync stop code
    @(posedge clk);
    #1;
    status = mkstat(32'h80000001, 8'h08, 8'h00, 8'h00);
    q.push_back(8'h33);
    n0  = n_strobe;
    bad = 0;
    repeat (10000) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("inv_rate_line_bad", bad, 0);
    chk("inv_rate_strobes", n_strobe - n0, 0);
    @(posedge clk);
    #1;
    status = mkstat(32'd9600, 8'h08, 8'h00, 8'hFF);
    n0  = n_strobe;
    bad = 0;
    repeat (10000) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("inv_stop_line_bad", bad, 0);
    chk("inv_stop_strobes", n_strobe - n0, 0);
    q.delete();
    repeat (3) @(posedge clk);

    // Reset in the middle of the data bits, then hold off with cts_n
    #1;
    status = mkstat(32'd9600, 8'h08, 8'h00, 8'h00);
    q.push_back(8'h00);
    wait_strobe("rst", ok);
    repeat (50) @(negedge clk);
    chk("rst_mid_data_txd", txd, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cts_n = 1'b1;
    q.push_back(8'hA5);
    @(negedge clk);
    chk("rst_cycle_strobe", ifc.strobe, 0);
    @(negedge clk);
    chk("rst_after_txd", txd, 1);
    chk("rst_after_busy", busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    n0  = n_strobe;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("cts_hold_line_bad", bad, 0);
    chk("cts_hold_strobes", n_strobe - n0, 0);
    @(posedge clk);
    #1 cts_n = 1'b0;
    wait_strobe("after_rst", ok);
    if (ok) check_frame(va5, "after_rst");

    chk("strobe_rule_violations", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
